subleq_mem_arbiter: RTL and testbench

//  Shares the single 1024x32 Subleq memory port between the Subleq core and a host

---
 rtl/subleq_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_subleq_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_mem_arbiter.sv
// subleq_mem_arbiter
// Shares the single Subleq memory port between the core and the host
// loader/debug port. At most one requester is granted per cycle: round-robin
// on contention, an optional host burst lock, and a starvation guard that
// lets a waiting core break a long host lock.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_ARB  | round-robin between core and host, loser of a contest wins next
// ST_LOCK | host keeps ownership; core waits until host releases or starves
module subleq_mem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_core_req,
    input  logic              i_core_we,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic              o_core_gnt,
    output logic              o_core_rvalid,
    output logic [DATA_W-1:0] o_core_rdata,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    input  logic              i_host_lock,
    output logic              o_host_gnt,
    output logic              o_host_rvalid,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_host;     // 1: host won last grant, so core wins next contest
    logic        w_last_host_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_nxt;
    logic        w_core_gnt;
    logic        w_host_gnt;

    // Grant decision, next state, round-robin pointer and core wait counter
    always_comb begin
        w_core_gnt      = 1'b0;
        w_host_gnt      = 1'b0;
        w_state_nxt     = r_state;
        w_last_host_nxt = r_last_host;
        w_wait_nxt      = 8'd0;

        if (!i_reset) begin
            unique case (r_state)
                ST_ARB: begin
                    if (i_core_req && i_host_req) begin
                        w_core_gnt = r_last_host;
                        w_host_gnt = !r_last_host;
                    end else begin
                        w_core_gnt = i_core_req;
                        w_host_gnt = i_host_req;
                    end
                    if (w_host_gnt && i_host_lock) begin
                        w_state_nxt = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    // >= rather than == so a counter that somehow overshoots still breaks the lock
                    if (i_core_req && (r_wait_cnt >= MAX_WAIT_C)) begin
                        w_core_gnt  = 1'b1;
                        w_state_nxt = ST_ARB;
                    end else if (!i_host_req) begin
                        w_state_nxt = ST_ARB;
                    end else begin
                        w_host_gnt = 1'b1;
                        if (!i_host_lock) begin
                            w_state_nxt = ST_ARB;
                        end
                    end
                end
                default: w_state_nxt = ST_ARB;
            endcase

            if (w_core_gnt) begin
                w_last_host_nxt = 1'b0;
            end else if (w_host_gnt) begin
                w_last_host_nxt = 1'b1;
            end

            if (i_core_req && !w_core_gnt) begin
                w_wait_nxt = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;
            end
        end
    end

    // Memory port mux: winner drives the port, all zero when idle
    always_comb begin
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        if (w_core_gnt) begin
            o_mem_addr  = i_core_addr;
            o_mem_we    = i_core_we;
            o_mem_wdata = i_core_wdata;
        end else if (w_host_gnt) begin
            o_mem_addr  = i_host_addr;
            o_mem_we    = i_host_we;
            o_mem_wdata = i_host_wdata;
        end
    end

    assign o_core_gnt = w_core_gnt;
    assign o_host_gnt = w_host_gnt;

    // Arbiter state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_ARB;
            r_last_host <= 1'b1;
            r_wait_cnt  <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_host <= w_last_host_nxt;
            r_wait_cnt  <= w_wait_nxt;
        end
    end

    // Read return: capture data at the grant edge, one-cycle valid pulse
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_core_rvalid <= 1'b0;
            o_core_rdata  <= '0;
            o_host_rvalid <= 1'b0;
            o_host_rdata  <= '0;
        end else begin
            o_core_rvalid <= w_core_gnt && !i_core_we;
            o_host_rvalid <= w_host_gnt && !i_host_we;
            if (w_core_gnt && !i_core_we) begin
                o_core_rdata <= i_mem_rdata;
            end
            if (w_host_gnt && !i_host_we) begin
                o_host_rdata <= i_mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// tb_subleq_mem_arbiter
// Directed scenarios followed by randomized traffic, checked each cycle
// against a behavioural model of the arbitration rules and a golden memory.
module tb_subleq_mem_arbiter;

    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, host_req, host_we, host_lock;
    logic [9:0]  core_addr, host_addr;
    logic [31:0] core_wdata, host_wdata;
    logic        core_gnt, core_rvalid, host_gnt, host_rvalid;
    logic [31:0] core_rdata, host_rdata;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] tb_mem  [1024];
    logic [31:0] ref_mem [1024];
    logic        fill_mem;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    bit          m_locked;
    bit          m_core_next;
    int          m_core_wait;
    bit          m_core_rv, m_host_rv;
    logic [31:0] m_core_rd, m_host_rd;
    logic        obs_core_g, obs_host_g;

    subleq_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_core_req   (core_req),
        .i_core_we    (core_we),
        .i_core_addr  (core_addr),
        .i_core_wdata (core_wdata),
        .o_core_gnt   (core_gnt),
        .o_core_rvalid(core_rvalid),
        .o_core_rdata (core_rdata),
        .i_host_req   (host_req),
        .i_host_we    (host_we),
        .i_host_addr  (host_addr),
        .i_host_wdata (host_wdata),
        .i_host_lock  (host_lock),
        .o_host_gnt   (host_gnt),
        .o_host_rvalid(host_rvalid),
        .o_host_rdata (host_rdata),
        .o_mem_addr   (mem_addr),
        .o_mem_we     (mem_we),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 5) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(i));
    endfunction

    // memory array behind the port
    always @(posedge clk) begin
        if (fill_mem) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= init_word(i);
        end else if (mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = tb_mem[mem_addr];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // one clock cycle: check combinational grant/port, then registered returns
    task automatic step();
        logic        eg_c, eg_h, ew;
        logic [9:0]  ea;
        logic [31:0] ed;
        @(negedge clk);
        eg_c = 1'b0;
        eg_h = 1'b0;
        if (!reset) begin
            if (!m_locked) begin
                if (core_req && host_req) begin
                    eg_c = m_core_next;
                    eg_h = !m_core_next;
                end else begin
                    eg_c = core_req;
                    eg_h = host_req;
                end
            end else if (core_req && m_core_wait >= MAX_WAIT) begin
                eg_c = 1'b1;
            end else begin
                eg_h = host_req;
            end
        end
        ea = eg_c ? core_addr : (eg_h ? host_addr : 10'd0);
        ew = eg_c ? core_we : (eg_h ? host_we : 1'b0);
        ed = eg_c ? core_wdata : (eg_h ? host_wdata : 32'd0);
        check_val("core_gnt", core_gnt, eg_c);
        check_val("host_gnt", host_gnt, eg_h);
        check_val("mem_addr", mem_addr, ea);
        check_val("mem_we", mem_we, ew);
        check_val("mem_wdata", mem_wdata, ed);
        obs_core_g = core_gnt;
        obs_host_g = host_gnt;

        @(posedge clk);
        #1;
        if (reset) begin
            m_locked    = 0;
            m_core_next = 1;
            m_core_wait = 0;
            m_core_rv   = 0;
            m_host_rv   = 0;
            m_core_rd   = 32'd0;
            m_host_rd   = 32'd0;
        end else begin
            m_core_rv = eg_c && !core_we;
            m_host_rv = eg_h && !host_we;
            if (m_core_rv) m_core_rd = ref_mem[core_addr];
            if (m_host_rv) m_host_rd = ref_mem[host_addr];
            if (ew) ref_mem[ea] = ed;
            if (eg_c) m_core_next = 0;
            if (eg_h) m_core_next = 1;
            m_core_wait = (core_req && !eg_c) ? m_core_wait + 1 : 0;
            if (!m_locked) begin
                m_locked = eg_h && host_lock;
            end else if (eg_c || !host_req || (eg_h && !host_lock)) begin
                m_locked = 0;
            end
        end
        check_val("core_rvalid", core_rvalid, m_core_rv);
        check_val("host_rvalid", host_rvalid, m_host_rv);
        check_val("core_rdata", core_rdata, m_core_rd);
        check_val("host_rdata", host_rdata, m_host_rd);
    endtask

    task automatic set_idle();
        reset     = 1'b0;
        core_req  = 1'b0;
        host_req  = 1'b0;
        host_lock = 1'b0;
        core_we   = 1'b0;
        host_we   = 1'b0;
    endtask

    task automatic core_rd(input logic [9:0] a);
        core_req = 1'b1; core_we = 1'b0; core_addr = a; core_wdata = 32'd0;
    endtask

    task automatic host_op(input logic we, input logic [9:0] a, input logic [31:0] d, input logic lk);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; host_lock = lk;
    endtask

    initial begin
        int host_cnt;
        set_idle();
        core_addr = 0; core_wdata = 0; host_addr = 0; host_wdata = 0;
        reset = 1'b1;
        fill_mem = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        m_locked = 0; m_core_next = 1; m_core_wait = 0;
        m_core_rv = 0; m_host_rv = 0; m_core_rd = 0; m_host_rd = 0;
        step();
        fill_mem = 1'b0;
        step();

        // core-only read of addr 5
        set_idle();
        core_rd(10'd5);
        step();
        check_val("t1_gnt", obs_core_g, 1'b1);
        check_val("t1_rvalid", core_rvalid, 1'b1);
        check_val("t1_rdata", core_rdata, 32'hDEADBEEF);
        check_val("t1_host_rvalid", host_rvalid, 1'b0);
        set_idle();
        step();
        check_val("t1_pulse", core_rvalid, 1'b0);

        // contention right after reset alternates core, host, core...
        reset = 1'b1;
        step();
        reset = 1'b0;
        core_rd(10'd1);
        host_op(1'b0, 10'd2, 32'd0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step();
            check_val("t2_core_turn", obs_core_g, (k % 2 == 0) ? 1'b1 : 1'b0);
            check_val("t2_one_gnt", obs_core_g & obs_host_g, 1'b0);
        end

        // host write then core read of same address
        set_idle();
        host_op(1'b1, 10'd3, 32'h0000_0007, 1'b0);
        step();
        set_idle();
        core_rd(10'd3);
        step();
        check_val("t3_rdata", core_rdata, 32'h0000_0007);

        // host lock with core starving: host owns 8 cycles, then core
        set_idle();
        core_rd(10'd0);
        step();
        core_rd(10'd4);
        host_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            host_op(1'b1, 10'(16 + k), 32'h1000 + 32'(k), 1'b1);
            step();
            if (obs_core_g) break;
            if (obs_host_g) host_cnt++;
        end
        check_val("t4_host_cycles", 64'(host_cnt), 64'd8);
        check_val("t4_core_gnt", obs_core_g, 1'b1);
        host_req = 1'b0;
        core_rd(10'd4);
        step();
        check_val("t4_back_to_arb", obs_core_g, 1'b1);

        // reset during a host write grant
        set_idle();
        core_rd(10'd6);
        step();
        core_req = 1'b0;
        reset = 1'b1;
        host_op(1'b1, 10'd9, 32'h1234_5678, 1'b1);
        step();
        check_val("t5_no_gnt", obs_host_g, 1'b0);
        check_val("t5_rvalid", core_rvalid, 1'b0);
        check_val("t5_mem", tb_mem[9], init_word(9));
        reset = 1'b0;
        core_rd(10'd7);
        host_op(1'b0, 10'd8, 32'd0, 1'b0);
        step();
        check_val("t5_core_first", obs_core_g, 1'b1);

        // host drops lock with core waiting two cycles
        set_idle();
        core_rd(10'd0);
        step();
        core_rd(10'd11);
        host_op(1'b1, 10'd12, 32'hABCD, 1'b1);
        step();
        check_val("t6_host_a", obs_host_g, 1'b1);
        host_op(1'b1, 10'd13, 32'hBCDE, 1'b0);
        step();
        check_val("t6_host_b", obs_host_g, 1'b1);
        host_op(1'b1, 10'd14, 32'hCDEF, 1'b1);
        step();
        check_val("t6_core", obs_core_g, 1'b1);

        // randomized traffic, second half with heavy host locking
        set_idle();
        obs_core_g = 1'b0;
        obs_host_g = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            int p_host, p_lock;
            p_host = (n < 1500) ? 60 : 90;
            p_lock = (n < 1500) ? 30 : 70;
            if (core_req && obs_core_g) core_req = 1'b0;
            if (host_req && obs_host_g) host_req = 1'b0;
            if (!core_req && $urandom_range(99) < 60) begin
                core_req   = 1'b1;
                core_we    = 1'($urandom_range(1));
                core_addr  = 10'($urandom_range(15));
                core_wdata = $urandom;
            end
            if (!host_req && $urandom_range(99) < p_host) begin
                host_req   = 1'b1;
                host_we    = 1'($urandom_range(1));
                host_addr  = 10'($urandom_range(15));
                host_wdata = $urandom;
            end
            host_lock = ($urandom_range(99) < p_lock);
            reset     = ($urandom_range(99) < 1);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
